// File: rtl/word_sub_add_seq.sv
// Multi-byte add/subtract sequencer: streams wide operands LSB byte first through a
// single 8-bit subtract/add stage, chaining borrow/carry between bytes.

module eight_bit_sub_add (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       B_CIN,
  input  logic       SUB_ADD,
  output logic [7:0] D_S,
  output logic       B_COUT
);

  logic c;

  // Ripple through the byte; the borrow chain differs from the carry chain only in ~a.
  always_comb begin
    c   = B_CIN;
    D_S = '0;
    for (int i = 0; i < 8; i++) begin
      D_S[i] = A[i] ^ B[i] ^ c;
      if (SUB_ADD)
        c = (~A[i] & B[i]) | (~A[i] & c) | (B[i] & c);
      else
        c = (A[i] & B[i]) | (A[i] & c) | (B[i] & c);
    end
    B_COUT = c;
  end

endmodule

module word_sub_add_seq #(
  parameter int N_BYTES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SUB_ADD,
  input  logic [8*N_BYTES-1:0] A,
  input  logic [8*N_BYTES-1:0] B,
  input  logic                 B_CIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [8*N_BYTES-1:0] RESULT,
  output logic                 B_COUT,
  output logic                 ZERO,
  output logic                 NEG,
  output logic                 OVF
);

  localparam int W     = 8 * N_BYTES;
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               chain_q, chain_d;
  logic [W-1:0]       a_q, b_q;
  logic               cin_q, op_q;
  logic [W-1:0]       part_q, part_d;
  logic               capture, finish, last_byte;

  logic [7:0]         st_a, st_b, st_ds;
  logic               st_cin, st_cout;

  logic [W-1:0]       result_q;
  logic               cout_q, zero_q, neg_q, ovf_q;
  logic               ovf_next;

  assign last_byte = (idx_q == IDX_W'(N_BYTES - 1));
  assign st_a      = a_q[{idx_q, 3'b000} +: 8];
  assign st_b      = b_q[{idx_q, 3'b000} +: 8];
  assign st_cin    = (idx_q == '0) ? cin_q : chain_q;

  eight_bit_sub_add u_stage (
    .A      (st_a),
    .B      (st_b),
    .B_CIN  (st_cin),
    .SUB_ADD(op_q),
    .D_S    (st_ds),
    .B_COUT (st_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chain_d = chain_q;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          idx_d   = '0;
          capture = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        chain_d = st_cout;
        idx_d   = idx_q + 1'b1;
        if (last_byte) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Partial result with the current byte merged in; on the last byte this is the full result.
  always_comb begin
    part_d = part_q;
    if (state_q == S_RUN)
      part_d[{idx_q, 3'b000} +: 8] = st_ds;
  end

  // Signed overflow from operand MSBs and the result MSB; subtract flips b's role.
  always_comb begin
    if (op_q)
      ovf_next = (a_q[W-1] != b_q[W-1]) && (part_d[W-1] != a_q[W-1]);
    else
      ovf_next = (a_q[W-1] == b_q[W-1]) && (part_d[W-1] != a_q[W-1]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= B_CIN;
      op_q  <= SUB_ADD;
    end
    if (state_q == S_RUN)
      part_q <= part_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (finish) begin
      result_q <= part_d;
      cout_q   <= st_cout;
      zero_q   <= (part_d == '0);
      neg_q    <= part_d[W-1];
      ovf_q    <= ovf_next;
    end
  end

  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;
  assign B_COUT = cout_q;
  assign ZERO   = zero_q;
  assign NEG    = neg_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_word_sub_add_seq.sv
// Self-checking bench for word_sub_add_seq: 16-bit and 32-bit instances checked
// against a wide-arithmetic reference model.

module tb_word_sub_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start4;
  logic [31:0] a_in, b_in;
  logic        cin_in, sub_in;

  logic        busy2, done2, cout2, zero2, neg2, ovf2;
  logic [15:0] res2;
  logic        busy4, done4, cout4, zero4, neg4, ovf4;
  logic [31:0] res4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  word_sub_add_seq #(.N_BYTES(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .SUB_ADD(sub_in),
    .A(a_in[15:0]), .B(b_in[15:0]), .B_CIN(cin_in),
    .BUSY(busy2), .DONE(done2), .RESULT(res2),
    .B_COUT(cout2), .ZERO(zero2), .NEG(neg2), .OVF(ovf2)
  );

  word_sub_add_seq #(.N_BYTES(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .SUB_ADD(sub_in),
    .A(a_in), .B(b_in), .B_CIN(cin_in),
    .BUSY(busy4), .DONE(done4), .RESULT(res4),
    .B_COUT(cout4), .ZERO(zero4), .NEG(neg4), .OVF(ovf4)
  );

  // Reference: exact integer arithmetic; borrow/carry is bit W of the wrapped result,
  // overflow is the true signed result falling outside the W-bit range.
  function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint unsigned m, au, bu, full, res;
    longint          sa, sb, ts, lim;
    logic            cout, zero, neg, ovf;
    m    = (64'd1 << w) - 64'd1;
    au   = {32'd0, a} & m;
    bu   = {32'd0, b} & m;
    full = sub ? (au - bu - {63'd0, cin}) : (au + bu + {63'd0, cin});
    res  = full & m;
    cout = full[w];
    zero = (res == 0);
    neg  = res[w-1];
    lim  = longint'(64'd1 << (w - 1));
    sa   = au[w-1] ? longint'(au) - 2 * lim : longint'(au);
    sb   = bu[w-1] ? longint'(bu) - 2 * lim : longint'(bu);
    ts   = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    ovf  = (ts >= lim) || (ts < -lim);
    return {res[31:0], cout, zero, neg, ovf};
  endfunction

  function automatic logic [35:0] obs(input int w);
    if (w == 16) return {16'd0, res2, cout2, zero2, neg2, ovf2};
    return {res4, cout4, zero4, neg4, ovf4};
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 16) ? busy2 : busy4;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 16) ? done2 : done4;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 16) start2 = v;
    else         start4 = v;
  endtask

  // One operation: checks held outputs during RUN, latency, BUSY length, result and hold after.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input bit noise, input string name);
    logic [35:0] expv, prev;
    int          busy_n, done_k;
    prev = obs(w);
    expv = model(w, a, b, cin, sub);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    set_start(w, 1'b1);
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total_cnt++;
        if (obs(w) !== prev)
          $display("FAIL %s hold_during_run: got %h expected %h", name, obs(w), prev);
        else pass_cnt++;
      end
      if (busy_of(w)) busy_n++;
      if (busy_of(w) && noise) begin
        set_start(w, 1'b1);
        a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
      end else begin
        set_start(w, 1'b0);
      end
      if (done_of(w)) begin
        done_k = k;
        break;
      end
    end
    total_cnt++;
    if (done_k != w / 8 + 1)
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_k, w / 8 + 1);
    else pass_cnt++;
    total_cnt++;
    if (busy_n != w / 8)
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, w / 8);
    else pass_cnt++;
    total_cnt++;
    if (obs(w) !== expv)
      $display("FAIL %s result{res,cout,zero,neg,ovf}: got %h expected %h", name, obs(w), expv);
    else pass_cnt++;
    set_start(w, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (done_of(w) !== 1'b0 || obs(w) !== expv)
      $display("FAIL %s hold_after_done: got done=%b %h expected done=0 %h",
               name, done_of(w), obs(w), expv);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy2, done2, obs(16)} !== 38'd0)
      $display("FAIL reset_n2: got %h expected 0", {busy2, done2, obs(16)});
    else pass_cnt++;
    total_cnt++;
    if ({busy4, done4, obs(32)} !== 38'd0)
      $display("FAIL reset_n4: got %h expected 0", {busy4, done4, obs(32)});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(16, 32'h1234, 32'h0F0F, 1'b0, 1'b0, 1'b0, "add_basic");
  endtask

  task automatic test_sub_borrow();
    run_op(16, 32'h0100, 32'h0001, 1'b0, 1'b1, 1'b0, "sub_cross_borrow");
    run_op(16, 32'h0000, 32'h0001, 1'b0, 1'b1, 1'b0, "sub_underflow");
  endtask

  task automatic test_overflow();
    run_op(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, "add_ovf");
    run_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, "add_zero_carry");
    run_op(16, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
    run_op(16, 32'h00FF, 32'h0000, 1'b1, 1'b0, 1'b0, "add_cin");
  endtask

  task automatic test_ignore_during_run();
    run_op(16, 32'hA5C3, 32'h3C5A, 1'b1, 1'b1, 1'b1, "start_ignored_in_run");
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp1, exp2;
    int          d1, d2, n_done;
    exp1 = model(16, 32'h1111, 32'h2222, 1'b0, 1'b0);
    exp2 = model(16, 32'h0005, 32'h0009, 1'b0, 1'b1);
    @(negedge clk);
    a_in = 32'h1111; b_in = 32'h2222; cin_in = 1'b0; sub_in = 1'b0; start2 = 1'b1;
    d1 = 0; d2 = 0; n_done = 0;
    for (int k = 1; k <= 15 && n_done < 2; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        n_done++;
        if (n_done == 1) begin
          d1 = k;
          total_cnt++;
          if (obs(16) !== exp1)
            $display("FAIL b2b_first: got %h expected %h", obs(16), exp1);
          else pass_cnt++;
          a_in = 32'h0005; b_in = 32'h0009; cin_in = 1'b0; sub_in = 1'b1; start2 = 1'b1;
        end else begin
          d2 = k;
          total_cnt++;
          if (obs(16) !== exp2)
            $display("FAIL b2b_second: got %h expected %h", obs(16), exp2);
          else pass_cnt++;
        end
      end
    end
    start2 = 1'b0;
    total_cnt++;
    if (n_done != 2 || d2 - d1 != 3)
      $display("FAIL b2b_spacing: got dones=%0d spacing=%0d expected dones=2 spacing=3",
               n_done, d2 - d1);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    @(negedge clk);
    a_in = 32'h4321; b_in = 32'h1234; cin_in = 1'b0; sub_in = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({busy2, done2, obs(16)} !== 38'd0)
      $display("FAIL abort_outputs: got %h expected 0", {busy2, done2, obs(16)});
    else pass_cnt++;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done2 || busy2) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0)
      $display("FAIL abort_no_done: got activity=%b expected 0", seen_done);
    else pass_cnt++;
    run_op(16, 32'h1234, 32'h0F0F, 1'b0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_wide();
    run_op(32, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "n4_add_wrap");
    run_op(32, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "n4_sub_ovf");
    for (int i = 0; i < 8; i++)
      run_op(32, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), "n4_random");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(16, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), "n2_random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_borrow();
    test_overflow();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
